mem_bus_router: RTL

- Sits between the CPU memory port (valid/ready, picorv32-style) and the memory-mapped slaves: the BRAM controller, the UART register block and the LED register.
- Decodes the request address and forwards the transaction to exactly one slave.
- Holds the slave request until that slave answers, then returns registered read data to the CPU with a one-cycle mem_ready pulse.
- Unmapped addresses get an immediate error response.

---
 rtl/mem_bus_router.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_router.sv
// CPU memory port to BRAM / UART / LED slave router with registered responses.
// Optional BUS_TIMEOUT_EN: bounded slave wait with an error response.
module mem_bus_router #(
    parameter logic [31:0] BRAM_BYTES     = 32'd8192,
    parameter logic [31:0] UART_BASE      = 32'hF000_0000,
    parameter logic [31:0] LED_BASE       = 32'hF000_1000,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        bram_valid,
    output logic        uart_valid,
    output logic        led_valid,
    input  logic        bram_ready,
    input  logic        uart_ready,
    input  logic        led_ready,
    input  logic [31:0] bram_rdata,
    input  logic [31:0] uart_rdata,
    input  logic [31:0] led_rdata,
    output logic        bus_error
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state;
    logic        hit_bram;
    logic        hit_uart;
    logic        hit_led;
    logic        sel_ready;
    logic [31:0] sel_rdata;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 8-bit wait counter");
    end

`ifdef BUS_TIMEOUT_EN
    logic [7:0] wait_cnt;
`endif

    always_comb begin
        hit_bram = mem_addr < BRAM_BYTES;
        hit_uart = mem_addr[31:12] == UART_BASE[31:12];
        hit_led  = mem_addr[31:12] == LED_BASE[31:12];
    end

    // The live valid doubles as the slave select while in ISSUE.
    always_comb begin
        sel_ready = (bram_valid & bram_ready) |
                    (uart_valid & uart_ready) |
                    (led_valid & led_ready);
        sel_rdata = 32'h0;
        unique case (1'b1)
            bram_valid: sel_rdata = bram_rdata;
            uart_valid: sel_rdata = uart_rdata;
            led_valid:  sel_rdata = led_rdata;
            default:    sel_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_ready  <= 1'b0;
            bus_error  <= 1'b0;
            mem_rdata  <= 32'h0;
            s_addr     <= 32'h0;
            s_wdata    <= 32'h0;
            s_wstrb    <= 4'h0;
            bram_valid <= 1'b0;
            uart_valid <= 1'b0;
            led_valid  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt   <= 8'h0;
`endif
        end else begin
            mem_ready <= 1'b0;
            bus_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_valid) begin
                        s_addr  <= mem_addr;
                        s_wdata <= mem_wdata;
                        s_wstrb <= mem_wstrb;
`ifdef BUS_TIMEOUT_EN
                        wait_cnt <= 8'h0;
`endif
                        if (hit_bram) begin
                            bram_valid <= 1'b1;
                            state      <= ISSUE;
                        end else if (hit_uart) begin
                            uart_valid <= 1'b1;
                            state      <= ISSUE;
                        end else if (hit_led) begin
                            led_valid <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            mem_rdata <= ERR_RDATA;
                            mem_ready <= 1'b1;
                            bus_error <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    if (sel_ready) begin
                        mem_rdata  <= (s_wstrb == 4'h0) ? sel_rdata : 32'h0;
                        mem_ready  <= 1'b1;
                        bram_valid <= 1'b0;
                        uart_valid <= 1'b0;
                        led_valid  <= 1'b0;
                        state      <= RESP;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (wait_cnt + 8'd1 == 8'(TIMEOUT_CYCLES)) begin
                        mem_rdata  <= ERR_RDATA;
                        mem_ready  <= 1'b1;
                        bus_error  <= 1'b1;
                        bram_valid <= 1'b0;
                        uart_valid <= 1'b0;
                        led_valid  <= 1'b0;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
